dcache_ctrl: RTL and testbench

//  Blocking, direct-mapped, write-back/write-allocate data cache between the MEM-stage load/store

---
 rtl/dcache_pkg.sv | 44 ++++
 rtl/dcache_array.sv | 44 ++++
 rtl/dcache_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dcache_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: geometry, FSM states and line layout for the D-cache.
// Shared by dcache_array and dcache_ctrl.
package dcache_pkg;

  localparam int LINES  = 8;
  localparam int WPL    = 4;
  localparam int ABITS  = 14;
  localparam int OFF_W  = $clog2(WPL);
  localparam int IDX_W  = $clog2(LINES);
  localparam int MA_W   = ABITS - 2;
  localparam int TAG_W  = MA_W - IDX_W - OFF_W;
  localparam int BEAT_W = OFF_W + 1;

  localparam logic [BEAT_W-1:0] WB_LAST = BEAT_W'(WPL - 1);
  localparam logic [BEAT_W-1:0] RF_LAST = BEAT_W'(WPL);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL,
    RESPOND
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_W-1:0]     tag;
    logic [WPL-1:0][31:0] data;
  } line_t;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag/flag/data storage, async read by index,
// one byte-masked word write, tag fill, dirty set, global invalidate.
module dcache_array
  import dcache_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             wr_en_i,
  input  logic [OFF_W-1:0] wr_word_i,
  input  logic [3:0]       wr_be_i,
  input  logic [31:0]      wr_data_i,
  input  logic             set_dirty_i,
  input  logic             fill_i,
  input  logic [TAG_W-1:0] fill_tag_i,
  output line_t            line_o
);

  line_t lines_q [LINES];

  assign line_o = lines_q[idx_i];

  // Only the flags need reset; data and tags are don't-care while invalid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LINES; i++) begin
        lines_q[i].valid <= 1'b0;
        lines_q[i].dirty <= 1'b0;
      end
    end else begin
      if (wr_en_i) begin
        lines_q[idx_i].data[wr_word_i] <= be_merge(
          lines_q[idx_i].data[wr_word_i], wr_data_i, wr_be_i);
      end
      if (set_dirty_i) lines_q[idx_i].dirty <= 1'b1;
      if (fill_i) begin
        lines_q[idx_i].tag   <= fill_tag_i;
        lines_q[idx_i].valid <= 1'b1;
        lines_q[idx_i].dirty <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: blocking direct-mapped write-back/write-allocate D-cache.
// Define DCACHE_STATS_EN to add saturating HIT_CNT/MISS_CNT outputs.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  input  logic             REQ_WE,
  input  logic [ABITS-1:0] REQ_ADDR,
  input  logic [3:0]       REQ_BE,
  input  logic [31:0]      REQ_WDATA,
  output logic [31:0]      RESP_DATA,
  output logic             STALL,
  output logic             D_MEM_CSN,
  output logic             D_MEM_WEN,
  output logic [MA_W-1:0]  D_MEM_ADDR,
  output logic [3:0]       D_MEM_BE,
  output logic [31:0]      D_MEM_DOUT,
  input  logic [31:0]      D_MEM_DI
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]      HIT_CNT,
  output logic [31:0]      MISS_CNT
`endif
);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [OFF_W-1:0]    req_word;
  line_t               cur;
  logic                hit;
  logic                serve;
  logic                wr_en;
  logic [OFF_W-1:0]    wr_word;
  logic [3:0]          wr_be;
  logic [31:0]         wr_data;
  logic                set_dirty;
  logic                fill;
  logic                unused_addr;

  assign req_tag     = REQ_ADDR[ABITS-1 -: TAG_W];
  assign req_idx     = REQ_ADDR[2+OFF_W +: IDX_W];
  assign req_word    = REQ_ADDR[2 +: OFF_W];
  assign unused_addr = ^REQ_ADDR[1:0];
  assign hit         = cur.valid && (cur.tag == req_tag);
  assign D_MEM_BE    = 4'hF;

  dcache_array u_array (
    .clk_i       (CLK),
    .rst_i       (RST),
    .idx_i       (req_idx),
    .wr_en_i     (wr_en),
    .wr_word_i   (wr_word),
    .wr_be_i     (wr_be),
    .wr_data_i   (wr_data),
    .set_dirty_i (set_dirty),
    .fill_i      (fill),
    .fill_tag_i  (req_tag),
    .line_o      (cur)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    STALL      = 1'b0;
    D_MEM_CSN  = 1'b1;
    D_MEM_WEN  = 1'b1;
    D_MEM_ADDR = '0;
    D_MEM_DOUT = '0;
    RESP_DATA  = '0;
    serve      = 1'b0;
    wr_en      = 1'b0;
    wr_word    = req_word;
    wr_be      = REQ_BE;
    wr_data    = REQ_WDATA;
    set_dirty  = 1'b0;
    fill       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          if (hit) begin
            serve = 1'b1;
          end else begin
            STALL   = 1'b1;
            beat_d  = '0;
            state_d = (cur.valid && cur.dirty) ? WRITEBACK : REFILL;
          end
        end
      end
      WRITEBACK: begin
        STALL      = REQ_VALID;
        D_MEM_CSN  = 1'b0;
        D_MEM_WEN  = 1'b0;
        D_MEM_ADDR = {cur.tag, req_idx, beat_q[OFF_W-1:0]};
        D_MEM_DOUT = cur.data[beat_q[OFF_W-1:0]];
        if (beat_q == WB_LAST) begin
          beat_d  = '0;
          state_d = REFILL;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      REFILL: begin
        STALL = REQ_VALID;
        if (beat_q != RF_LAST) begin
          D_MEM_CSN  = 1'b0;
          D_MEM_ADDR = {req_tag, req_idx, beat_q[OFF_W-1:0]};
        end
        // Read data lags its address by one cycle, so beat i fills word i-1.
        if (beat_q != '0) begin
          wr_en   = 1'b1;
          wr_word = OFF_W'(beat_q - 1'b1);
          wr_be   = 4'hF;
          wr_data = D_MEM_DI;
        end
        if (beat_q == RF_LAST) begin
          fill    = 1'b1;
          beat_d  = '0;
          state_d = RESPOND;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      RESPOND: begin
        serve   = REQ_VALID;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (serve) begin
      if (REQ_WE) begin
        wr_en     = 1'b1;
        set_dirty = 1'b1;
      end else begin
        RESP_DATA = cur.data[req_word];
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic        hit_evt;
  logic        miss_evt;

  assign hit_evt  = (state_q == IDLE) && REQ_VALID && hit;
  assign miss_evt = (state_q == IDLE) && REQ_VALID && !hit;
  assign HIT_CNT  = hit_cnt_q;
  assign MISS_CNT = miss_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_evt && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
      if (miss_evt && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end
`else
  // Statistics compiled out: no counter state exists in this build.
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed + random accesses checked against a
// flat-memory reference model with per-line residency bookkeeping.
module tb_dcache_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_WE = 1'b0;
  logic [13:0] REQ_ADDR = '0;
  logic [3:0]  REQ_BE = '0;
  logic [31:0] REQ_WDATA = '0;
  logic [31:0] RESP_DATA;
  logic        STALL;
  logic        D_MEM_CSN;
  logic        D_MEM_WEN;
  logic [11:0] D_MEM_ADDR;
  logic [3:0]  D_MEM_BE;
  logic [31:0] D_MEM_DOUT;
  logic [31:0] D_MEM_DI;
`ifdef DCACHE_STATS_EN
  logic [31:0] HIT_CNT;
  logic [31:0] MISS_CNT;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] seed = 32'h0;
  logic [31:0] mem [4096];
  bit          written [4096];
  logic [31:0] rd_q;
  logic [31:0] gold [4096];
  bit          m_valid [8];
  bit          m_dirty [8];
  int          m_tag [8];
  int          hits_m = 0;
  int          misses_m = 0;
  int          st;
  int          bad;
  logic [31:0] rd;

  dcache_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_VALID  (REQ_VALID),
    .REQ_WE     (REQ_WE),
    .REQ_ADDR   (REQ_ADDR),
    .REQ_BE     (REQ_BE),
    .REQ_WDATA  (REQ_WDATA),
    .RESP_DATA  (RESP_DATA),
    .STALL      (STALL),
    .D_MEM_CSN  (D_MEM_CSN),
    .D_MEM_WEN  (D_MEM_WEN),
    .D_MEM_ADDR (D_MEM_ADDR),
    .D_MEM_BE   (D_MEM_BE),
    .D_MEM_DOUT (D_MEM_DOUT),
    .D_MEM_DI   (D_MEM_DI)
`ifdef DCACHE_STATS_EN
    ,
    .HIT_CNT    (HIT_CNT),
    .MISS_CNT   (MISS_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memval(input int a);
    if (written[a]) return mem[a];
    return (32'(a) * 32'h9E3779B1) ^ seed;
  endfunction

  // Backing D-memory: one-cycle read latency.
  always @(posedge CLK) begin
    if (D_MEM_CSN === 1'b0) begin
      if (D_MEM_WEN === 1'b0) begin
        mem[D_MEM_ADDR]     <= D_MEM_DOUT;
        written[D_MEM_ADDR] <= 1'b1;
      end
      rd_q <= memval(int'(D_MEM_ADDR));
    end
  end
  assign D_MEM_DI = rd_q;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 0;
    end
    for (int w = 0; w < 4096; w++) gold[w] = memval(w);
    hits_m   = 0;
    misses_m = 0;
  endtask

  task automatic idle(input int n);
    REQ_VALID = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      chk("idle_stall", 32'(STALL), 32'd0);
      chk("idle_csn", 32'(D_MEM_CSN), 32'd1);
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic access(input bit we, input int w, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rdata);
    int idx, tag, exp_st, n;
    bit hit, done;
    logic [12:0] exp_q [$];
    logic [12:0] got_q [$];
    idx   = (w >> 2) & 7;
    tag   = w >> 5;
    hit   = m_valid[idx] && (m_tag[idx] == tag);
    rdata = '0;
    exp_st = 0;
    if (!hit) begin
      exp_st = 1 + 4 + 1;
      if (m_valid[idx] && m_dirty[idx]) begin
        exp_st += 4;
        for (int i = 0; i < 4; i++)
          exp_q.push_back({1'b0, 12'(m_tag[idx] * 32 + idx * 4 + i)});
      end
      for (int i = 0; i < 4; i++)
        exp_q.push_back({1'b1, 12'(tag * 32 + idx * 4 + i)});
    end
    REQ_VALID = 1'b1;
    REQ_WE    = we;
    REQ_ADDR  = 14'(w * 4);
    REQ_BE    = be;
    REQ_WDATA = wd;
    n    = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CLK);
      if (D_MEM_CSN === 1'b0) begin
        got_q.push_back({D_MEM_WEN, D_MEM_ADDR});
        if (D_MEM_WEN === 1'b0)
          chk("wb_data", D_MEM_DOUT, gold[D_MEM_ADDR]);
      end
      if (STALL === 1'b0) begin
        done  = 1'b1;
        rdata = RESP_DATA;
      end else begin
        n++;
      end
      @(posedge CLK);
      #1;
    end
    chk("done", 32'(done), 32'd1);
    chk("stall_cycles", 32'(n), 32'(exp_st));
    chk("txn_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk("txn", 32'(got_q[i]), 32'(exp_q[i]));
    if (!we) chk("rdata", rdata, gold[w]);
    if (hit) hits_m++;
    else begin
      misses_m++;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 1'b0;
    end
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) gold[w][8*b +: 8] = wd[8*b +: 8];
      m_dirty[idx] = 1'b1;
    end
  endtask

  initial begin
    seed = $urandom;
    reset_model();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_stall", 32'(STALL), 32'd0);
    chk("rst_csn", 32'(D_MEM_CSN), 32'd1);
    chk("rst_wen", 32'(D_MEM_WEN), 32'd1);
    chk("rst_addr", 32'(D_MEM_ADDR), 32'd0);
    chk("rst_dout", D_MEM_DOUT, 32'd0);
    chk("rst_be", 32'(D_MEM_BE), 32'hF);
    chk("rst_resp", RESP_DATA, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    access(1'b0, 'h010, 4'hF, 32'h0, rd);
    access(1'b0, 'h011, 4'hF, 32'h0, rd);
    access(1'b1, 'h010, 4'b0011, 32'hAAAA5555, rd);
    access(1'b0, 'h010, 4'hF, 32'h0, rd);
    chk("t3_low", 32'(rd[15:0]), 32'h5555);
    access(1'b0, 'h210, 4'hF, 32'h0, rd);
`ifdef DCACHE_STATS_EN
    chk("hit_cnt_t4", HIT_CNT, 32'd3);
    chk("miss_cnt_t4", MISS_CNT, 32'd2);
`endif

    REQ_VALID = 1'b1;
    REQ_WE    = 1'b0;
    REQ_ADDR  = 14'h0040;
    REQ_BE    = 4'hF;
    st = 0;
    for (int c = 0; c < 20 && st < 4; c++) begin
      @(negedge CLK);
      if (STALL === 1'b1) st++;
      if (st < 4) begin
        @(posedge CLK);
        #1;
      end
    end
    chk("t5_reach_beat2", 32'(st), 32'd4);
    RST = 1'b1;
    REQ_VALID = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    reset_model();
    @(negedge CLK);
    chk("t5_stall", 32'(STALL), 32'd0);
    chk("t5_csn", 32'(D_MEM_CSN), 32'd1);
    @(posedge CLK);
    #1;
    access(1'b0, 'h010, 4'hF, 32'h0, rd);

    for (int k = 0; k < 300; k++) begin
      int w;
      w = $urandom_range(0, 127) + ($urandom_range(0, 3) == 0 ? 512 : 0);
      access(1'($urandom_range(0, 1)), w, 4'($urandom_range(1, 15)),
             $urandom, rd);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);
`ifdef DCACHE_STATS_EN
    chk("hit_cnt_end", HIT_CNT, 32'(hits_m));
    chk("miss_cnt_end", MISS_CNT, 32'(misses_m));
`endif

    bad = 0;
    for (int w = 0; w < 4096; w++) begin
      int idx;
      idx = (w >> 2) & 7;
      if (!(m_valid[idx] && m_dirty[idx] && m_tag[idx] == (w >> 5)))
        if (memval(w) !== gold[w]) bad++;
    end
    chk("backing_mem", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
